// File: rtl/ui_pkg.sv
// Shared UI definitions for the OLED screen sequencer.
//   screen_e   : committed/pending screen encoding (TITLE, MENU, GAME, OVER)
//   WIDTH/HEIGHT/NUM_PIXELS : 96x64 panel geometry
//   Col*       : common RGB565 colour constants
package ui_pkg;

    typedef enum logic [1:0] {
        ScrTitle = 2'd0,
        ScrMenu  = 2'd1,
        ScrGame  = 2'd2,
        ScrOver  = 2'd3
    } screen_e;

    localparam int unsigned WIDTH      = 96;
    localparam int unsigned HEIGHT     = 64;
    localparam int unsigned NUM_PIXELS = WIDTH * HEIGHT;

    localparam logic [15:0] ColBlack = 16'h0000;
    localparam logic [15:0] ColWhite = 16'hFFFF;
    localparam logic [15:0] ColRed   = 16'hF800;
    localparam logic [15:0] ColGreen = 16'h07E0;
    localparam logic [15:0] ColBlue  = 16'h001F;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level.
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   i_level : debounced button level
//   o_rise  : high for the single cycle in which i_level first reads 1
module btn_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    // History is loaded with the live level in reset so a button held
    // through reset does not produce an event on release of reset.
    always_ff @(posedge i_clk) begin
        r_prev <= i_level;
    end

    assign o_rise = i_level & ~r_prev & ~i_reset;

endmodule

// File: rtl/oled_screen_sequencer.sv
// Screen controller for the 96x64 OLED: TITLE -> MENU -> GAME -> OVER.
//   i_clk, i_reset        : pixel clock, synchronous active-high reset
//   i_pixel_index         : current pixel from the OLED driver
//   i_frame_begin         : start-of-frame pulse; screen changes commit only here
//   i_btn_c/u/d           : debounced select/up/down levels
//   i_game_over           : game-over level, honoured only in GAME
//   i_*_px                : RGB565 colours from the per-screen renderers
//   o_x, o_y              : column/row of i_pixel_index
//   o_screen              : committed screen
//   o_blink_on            : title icon visible phase
//   o_cursor              : menu cursor
//   o_game_start          : one-cycle pulse as GAME is committed
//   o_oled_data           : registered pixel colour
module oled_screen_sequencer
    import ui_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 15,
    parameter int unsigned OVER_FRAMES  = 120,
    parameter int unsigned MENU_ITEMS   = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [12:0] i_pixel_index,
    input  logic        i_frame_begin,
    input  logic        i_btn_c,
    input  logic        i_btn_u,
    input  logic        i_btn_d,
    input  logic        i_game_over,
    input  logic [15:0] i_title_px,
    input  logic [15:0] i_menu_px,
    input  logic [15:0] i_game_px,
    input  logic [15:0] i_over_px,
    output logic [6:0]  o_x,
    output logic [5:0]  o_y,
    output logic [1:0]  o_screen,
    output logic        o_blink_on,
    output logic [1:0]  o_cursor,
    output logic        o_game_start,
    output logic [15:0] o_oled_data
);

    localparam int unsigned BlinkW = $clog2(BLINK_FRAMES);
    localparam int unsigned OverW  = $clog2(OVER_FRAMES);

    logic w_c_rise, w_u_rise, w_d_rise;

    btn_edge u_btn_c (.i_clk(i_clk), .i_reset(i_reset), .i_level(i_btn_c), .o_rise(w_c_rise));
    btn_edge u_btn_u (.i_clk(i_clk), .i_reset(i_reset), .i_level(i_btn_u), .o_rise(w_u_rise));
    btn_edge u_btn_d (.i_clk(i_clk), .i_reset(i_reset), .i_level(i_btn_d), .o_rise(w_d_rise));

    screen_e             r_screen, w_screen_d;
    screen_e             r_pending, w_pending_d;
    logic [1:0]          r_cursor, w_cursor_d;
    logic                r_blink_on, w_blink_on_d;
    logic [BlinkW-1:0]   r_blink_cnt, w_blink_cnt_d;
    logic [OverW-1:0]    r_over_cnt, w_over_cnt_d;
    logic                r_game_start, w_game_start_d;
    logic [15:0]         r_oled_data, w_oled_data_d;
    logic                w_idle;

    assign o_x = 7'(i_pixel_index % 13'(WIDTH));
    assign o_y = 6'(i_pixel_index / 13'(WIDTH));

    always_comb begin
        w_pending_d    = r_pending;
        w_cursor_d     = r_cursor;
        w_blink_on_d   = 1'b1;
        w_blink_cnt_d  = '0;
        w_over_cnt_d   = '0;
        // Once a change is queued, hold off further events until it commits.
        w_idle         = (r_pending == r_screen);

        unique case (r_screen)
            ScrTitle: begin
                if (w_idle && w_c_rise) w_pending_d = ScrMenu;
                w_blink_on_d  = r_blink_on;
                w_blink_cnt_d = r_blink_cnt;
                if (i_frame_begin) begin
                    if (r_blink_cnt == BlinkW'(BLINK_FRAMES - 1)) begin
                        w_blink_cnt_d = '0;
                        w_blink_on_d  = ~r_blink_on;
                    end else begin
                        w_blink_cnt_d = r_blink_cnt + 1'b1;
                    end
                end
            end
            ScrMenu: begin
                // Cursor is frozen while GAME is pending and kept for the next MENU visit.
                if (w_idle) begin
                    if (w_c_rise) begin
                        w_pending_d = ScrGame;
                    end else if (w_u_rise && !w_d_rise) begin
                        w_cursor_d = (r_cursor == 2'd0) ? 2'(MENU_ITEMS - 1) : r_cursor - 2'd1;
                    end else if (w_d_rise && !w_u_rise) begin
                        w_cursor_d = (r_cursor == 2'(MENU_ITEMS - 1)) ? 2'd0 : r_cursor + 2'd1;
                    end
                end
            end
            ScrGame: begin
                if (w_idle && i_game_over) w_pending_d = ScrOver;
            end
            ScrOver: begin
                w_over_cnt_d = r_over_cnt;
                if (i_frame_begin && r_over_cnt != OverW'(OVER_FRAMES - 1)) begin
                    w_over_cnt_d = r_over_cnt + 1'b1;
                end
                // Counter holds frames since commit; this frame_begin is frame r_over_cnt+1.
                if (w_idle && (w_c_rise ||
                    (i_frame_begin && r_over_cnt == OverW'(OVER_FRAMES - 2)))) begin
                    w_pending_d = ScrTitle;
                end
            end
            default: ;
        endcase

        // Commit uses the pending value from before this cycle's events.
        w_screen_d      = i_frame_begin ? r_pending : r_screen;
        w_game_start_d  = i_frame_begin && (r_pending == ScrGame) && (r_screen != ScrGame);

        if (i_pixel_index >= 13'(NUM_PIXELS)) begin
            w_oled_data_d = ColBlack;
        end else begin
            unique case (r_screen)
                ScrTitle: w_oled_data_d = i_title_px;
                ScrMenu:  w_oled_data_d = i_menu_px;
                ScrGame:  w_oled_data_d = i_game_px;
                ScrOver:  w_oled_data_d = i_over_px;
                default:  w_oled_data_d = ColBlack;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_screen     <= ScrTitle;
            r_pending    <= ScrTitle;
            r_cursor     <= 2'd0;
            r_blink_on   <= 1'b1;
            r_blink_cnt  <= '0;
            r_over_cnt   <= '0;
            r_game_start <= 1'b0;
            r_oled_data  <= ColBlack;
        end else begin
            r_screen     <= w_screen_d;
            r_pending    <= w_pending_d;
            r_cursor     <= w_cursor_d;
            r_blink_on   <= w_blink_on_d;
            r_blink_cnt  <= w_blink_cnt_d;
            r_over_cnt   <= w_over_cnt_d;
            r_game_start <= w_game_start_d;
            r_oled_data  <= w_oled_data_d;
        end
    end

    assign o_screen     = r_screen;
    assign o_blink_on   = r_blink_on;
    assign o_cursor     = r_cursor;
    assign o_game_start = r_game_start;
    assign o_oled_data  = r_oled_data;

endmodule

// File: tb/tb_oled_screen_sequencer.sv
// Directed bench for oled_screen_sequencer.
module tb_oled_screen_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] pixel_index;
    logic        frame_begin, btn_c, btn_u, btn_d, game_over;
    logic [15:0] title_px, menu_px, game_px, over_px;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [1:0]  screen, cursor;
    logic        blink_on, game_start;
    logic [15:0] oled_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    oled_screen_sequencer dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_pixel_index(pixel_index),
        .i_frame_begin(frame_begin),
        .i_btn_c      (btn_c),
        .i_btn_u      (btn_u),
        .i_btn_d      (btn_d),
        .i_game_over  (game_over),
        .i_title_px   (title_px),
        .i_menu_px    (menu_px),
        .i_game_px    (game_px),
        .i_over_px    (over_px),
        .o_x          (x),
        .o_y          (y),
        .o_screen     (screen),
        .o_blink_on   (blink_on),
        .o_cursor     (cursor),
        .o_game_start (game_start),
        .o_oled_data  (oled_data)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame();
        frame_begin = 1'b1;
        step();
        frame_begin = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame();
            step();
        end
    endtask

    task automatic press_c();
        btn_c = 1'b1;
        step();
        btn_c = 1'b0;
        step();
    endtask

    task automatic press_ud(input logic u, input logic d);
        btn_u = u;
        btn_d = d;
        step();
        btn_u = 1'b0;
        btn_d = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; pixel_index = 13'd0; frame_begin = 1'b0;
        btn_c = 1'b1; btn_u = 1'b0; btn_d = 1'b0; game_over = 1'b0;
        title_px = 16'h07E0; menu_px = 16'hF800; game_px = 16'h001F; over_px = 16'hFFE0;
        @(negedge clk);
        step();
        step();
        check("rst_screen", 16'(screen), 16'd0);
        check("rst_blink", 16'(blink_on), 16'd1);
        check("rst_cursor", 16'(cursor), 16'd0);
        check("rst_game_start", 16'(game_start), 16'd0);
        check("rst_oled", oled_data, 16'h0000);

        // btnC held through reset must not fire
        reset = 1'b0;
        step();
        frames(2);
        check("held_btn_no_event", 16'(screen), 16'd0);
        btn_c = 1'b0;
        step();
        check("title_px", oled_data, 16'h07E0);

        // Fresh reset, then blink timing
        reset = 1'b1;
        step();
        reset = 1'b0;
        frames(14);
        check("blink_f14", 16'(blink_on), 16'd1);
        frames(1);
        check("blink_f15", 16'(blink_on), 16'd0);
        frames(14);
        check("blink_f29", 16'(blink_on), 16'd0);
        frames(1);
        check("blink_f30", 16'(blink_on), 16'd1);

        // btnC mid-frame: commit waits for frame_begin
        press_c();
        check("title_wait_commit", 16'(screen), 16'd0);
        pixel_index = 13'd200;
        #1;
        check("x_200", 16'(x), 16'd8);
        check("y_200", 16'(y), 16'd2);
        frame();
        check("menu_commit", 16'(screen), 16'd1);
        step();
        check("menu_blink", 16'(blink_on), 16'd1);
        check("menu_px", oled_data, 16'hF800);

        // Menu cursor
        press_ud(1'b1, 1'b0);
        check("cur_up_wrap", 16'(cursor), 16'd2);
        press_ud(1'b0, 1'b1);
        check("cur_dn_wrap", 16'(cursor), 16'd0);
        press_ud(1'b0, 1'b1);
        check("cur_dn_1", 16'(cursor), 16'd1);
        press_ud(1'b0, 1'b1);
        check("cur_dn_2", 16'(cursor), 16'd2);
        press_ud(1'b1, 1'b1);
        check("cur_ud_same", 16'(cursor), 16'd2);

        // Select -> GAME with start pulse
        press_c();
        check("game_pending", 16'(screen), 16'd1);
        check("no_early_start", 16'(game_start), 16'd0);
        press_ud(1'b1, 1'b0);
        check("cur_frozen", 16'(cursor), 16'd2);
        frame();
        check("game_commit", 16'(screen), 16'd2);
        check("game_start_hi", 16'(game_start), 16'd1);
        step();
        check("game_start_lo", 16'(game_start), 16'd0);
        check("game_px", oled_data, 16'h001F);
        pixel_index = 13'd6144;
        step();
        check("px_out_of_range", oled_data, 16'h0000);
        pixel_index = 13'd6143;
        step();
        check("px_last", oled_data, 16'h001F);

        // Buttons ignored in GAME; game_over -> OVER
        press_c();
        frames(1);
        check("game_btn_ignored", 16'(screen), 16'd2);
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        check("over_pending", 16'(screen), 16'd2);
        frame();
        check("over_commit", 16'(screen), 16'd3);
        step();
        check("over_px", oled_data, 16'hFFE0);
        frames(119);
        check("over_hold_119", 16'(screen), 16'd3);
        frames(1);
        check("over_timeout", 16'(screen), 16'd0);

        // Back round to OVER; cursor preserved in MENU
        press_c();
        frames(1);
        check("menu_again", 16'(screen), 16'd1);
        check("cursor_kept", 16'(cursor), 16'd2);
        press_c();
        frames(1);
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        frames(1);
        check("over_again", 16'(screen), 16'd3);
        press_c();
        check("over_btn_pending", 16'(screen), 16'd3);
        frames(1);
        check("over_btn_title", 16'(screen), 16'd0);

        // btnC coincident with frame_begin: one-frame lag
        btn_c = 1'b1;
        frame();
        btn_c = 1'b0;
        check("coinc_old_commit", 16'(screen), 16'd0);
        step();
        frames(1);
        check("coinc_next_commit", 16'(screen), 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
